// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_pkg
//  Brief    : Shared types, keymap and helpers for the 4x4 keypad encoder.
//  Revision : 1.0
// ============================================================================
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN      = 2'd0,
        DEB_PRESS = 2'd1,
        HELD      = 2'd2,
        DEB_REL   = 2'd3
    } kp_state_t;

    localparam logic [3:0] KEY_ENTER = 4'hE;
    localparam logic [3:0] KEY_CLEAR = 4'hF;

    // Indexed [row][col]; the * and # positions carry enter and clear.
    localparam logic [3:0] KEYMAP [0:3][0:3] = '{
        '{4'h1,      4'h2, 4'h3,      4'hA},
        '{4'h4,      4'h5, 4'h6,      4'hB},
        '{4'h7,      4'h8, 4'h9,      4'hC},
        '{KEY_ENTER, 4'h0, KEY_CLEAR, 4'hD}
    };

    function automatic logic is_one_cold(input logic [3:0] v);
        return ($countones(~v) == 1);
    endfunction

    function automatic logic [1:0] cold_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_encoder_if
//  Brief    : Keypad matrix lines plus the key_code / key_validn link.
//  Revision : 1.0
// ============================================================================
interface keypad_encoder_if;

    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_validn;

    modport master (
        input  row_n,
        output col_n,
        output key_code,
        output key_validn
    );

    modport slave (
        output row_n,
        input  col_n,
        input  key_code,
        input  key_validn
    );

endinterface
`default_nettype wire

// File: rtl/kp_sync.sv
`default_nettype none
// ============================================================================
//  Module   : kp_sync
//  Brief    : Parameterized 2-flop synchronizer, resets to all ones.
//  Revision : 1.0
// ============================================================================
module kp_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/keypad_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_encoder
//  Brief    : 4x4 keypad scanner/debouncer producing key_code + key_validn.
//  Revision : 1.0
// ============================================================================
module keypad_encoder
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 50_000,
    parameter int DEBOUNCE_CNT = 500_000
) (
    input  logic              clk,
    input  logic              reset_n,
    keypad_encoder_if.master  kp
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DEB_W = $clog2(DEBOUNCE_CNT);

    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] C_DEB_LAST = DEB_W'(DEBOUNCE_CNT - 1);

    localparam logic [1:0] ST_SCAN      = SCAN;
    localparam logic [1:0] ST_DEB_PRESS = DEB_PRESS;
    localparam logic [1:0] ST_HELD      = HELD;
    localparam logic [1:0] ST_DEB_REL   = DEB_REL;

    logic [3:0]       w_rs;
    logic [1:0]       w_col_next;

    logic [1:0]       r_state;
    logic [1:0]       r_col;
    logic [3:0]       r_col_n;
    logic [DIV_W-1:0] r_div;
    logic [DEB_W-1:0] r_deb;
    logic [3:0]       r_row_pat;
    logic [1:0]       r_row;
    logic [3:0]       r_key_code;
    logic             r_key_validn;

    kp_sync #(
        .WIDTH (4)
    ) u_row_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (kp.row_n),
        .o_q     (w_rs)
    );

    assign w_col_next = r_col + 2'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_SCAN;
            r_col        <= 2'd0;
            r_col_n      <= 4'b1110;
            r_div        <= '0;
            r_deb        <= '0;
            r_row_pat    <= 4'hF;
            r_row        <= 2'd0;
            r_key_code   <= 4'h0;
            r_key_validn <= 1'b1;
        end else begin
            case (r_state)
                ST_SCAN: begin
                    if (r_div == C_DIV_LAST) begin
                        r_div <= '0;
                        // Ghosted (multi-row) samples are treated like no press.
                        if (is_one_cold(w_rs)) begin
                            r_row_pat <= w_rs;
                            r_row     <= cold_index(w_rs);
                            r_deb     <= '0;
                            r_state   <= ST_DEB_PRESS;
                        end else begin
                            r_col   <= w_col_next;
                            r_col_n <= ~(4'b0001 << w_col_next);
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end

                ST_DEB_PRESS: begin
                    if (w_rs != r_row_pat) begin
                        r_div   <= '0;
                        r_state <= ST_SCAN;
                    end else if (r_deb == C_DEB_LAST) begin
                        // Code lands one edge ahead of the strobe for the receiver.
                        r_key_code <= KEYMAP[r_row][r_col];
                        r_state    <= ST_HELD;
                    end else begin
                        r_deb <= r_deb + 1'b1;
                    end
                end

                ST_HELD: begin
                    r_key_validn <= 1'b0;
                    if (w_rs == 4'hF) begin
                        r_deb   <= '0;
                        r_state <= ST_DEB_REL;
                    end
                end

                ST_DEB_REL: begin
                    if (w_rs != 4'hF) begin
                        r_state <= ST_HELD;
                    end else if (r_deb == C_DEB_LAST) begin
                        r_key_validn <= 1'b1;
                        r_div        <= '0;
                        r_col        <= w_col_next;
                        r_col_n      <= ~(4'b0001 << w_col_next);
                        r_state      <= ST_SCAN;
                    end else begin
                        r_deb <= r_deb + 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_SCAN;
                end
            endcase
        end
    end

    assign kp.col_n      = r_col_n;
    assign kp.key_code   = r_key_code;
    assign kp.key_validn = r_key_validn;

endmodule
`default_nettype wire

// File: tb/tb_keypad_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_encoder
//  Brief    : Self-checking bench with keypad matrix model and code scoreboard.
//  Revision : 1.0
// ============================================================================
module tb_keypad_encoder;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] press   = 16'h0000;   // bit row*4+col = contact closed

    int checks      = 0;
    int errors      = 0;
    int pulse_count = 0;

    logic [3:0] exp_q [$];

    keypad_encoder_if kif ();

    keypad_encoder #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .kp      (kif.master)
    );

    always #5 clk = ~clk;

    // A closed contact pulls its row low only while its column is driven.
    always_comb begin
        kif.row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (press[r*4+c] && (kif.col_n[c] === 1'b0)) kif.row_n[r] = 1'b0;
            end
        end
    end

    // Scoreboard: each falling strobe pops one expected code.
    logic       prev_validn = 1'b1;
    logic [3:0] prev_code   = 4'h0;
    logic [3:0] sb_exp;

    always @(negedge clk) begin
        if (prev_validn === 1'b1 && kif.key_validn === 1'b0) begin
            pulse_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_pulse: key_code=%h, no press expected", kif.key_code);
            end else begin
                sb_exp = exp_q.pop_front();
                if (kif.key_code !== sb_exp) begin
                    errors++;
                    $display("FAIL sb_code: got %h expected %h", kif.key_code, sb_exp);
                end
            end
            checks++;
            if (prev_code !== kif.key_code) begin
                errors++;
                $display("FAIL sb_setup: code before fall %h, at fall %h", prev_code, kif.key_code);
            end
        end else if (prev_validn === 1'b0 && kif.key_validn === 1'b0) begin
            checks++;
            if (kif.key_code !== prev_code) begin
                errors++;
                $display("FAIL sb_code_stable: changed %h -> %h while held", prev_code, kif.key_code);
            end
        end
        prev_validn = kif.key_validn;
        prev_code   = kif.key_code;
    end

    task automatic wait_validn(input logic level, input int budget, output int cycles);
        cycles = -1;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            if (kif.key_validn === level) begin
                cycles = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_col;
        reset_n = 1'b0;
        press   = 16'h0000;
        repeat (3) @(negedge clk);
        checks++;
        if (kif.col_n !== 4'b1110 || kif.key_validn !== 1'b1 || kif.key_code !== 4'h0) begin
            errors++;
            $display("FAIL reset_values: col_n=%b validn=%b code=%h, expected 1110/1/0",
                     kif.col_n, kif.key_validn, kif.key_code);
        end
        reset_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            exp_col = ~(4'b0001 << ((k / 4) % 4));
            checks++;
            if (kif.col_n !== exp_col) begin
                errors++;
                $display("FAIL scan_col k=%0d: col_n=%b expected %b", k, kif.col_n, exp_col);
            end
            checks++;
            if (kif.key_validn !== 1'b1 || kif.key_code !== 4'h0) begin
                errors++;
                $display("FAIL scan_idle k=%0d: validn=%b code=%h expected 1/0",
                         k, kif.key_validn, kif.key_code);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_clean_press();
        logic [3:0] c1, c2;
        logic       fell;
        int         n;
        press = 16'h0020;          // "5": row 1, col 1
        exp_q.push_back(4'h5);
        c1   = kif.key_code;
        c2   = kif.key_code;
        fell = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!fell && kif.key_validn === 1'b0) begin
                fell = 1'b1;
                checks++;
                if (c1 !== 4'h5 || c2 !== 4'h0) begin
                    errors++;
                    $display("FAIL press5_setup: code 1 cycle before=%h 2 before=%h, expected 5/0", c1, c2);
                end
            end
            if (!fell) begin
                c2 = c1;
                c1 = kif.key_code;
            end
        end
        checks++;
        if (!fell) begin
            errors++;
            $display("FAIL press5_timeout: key_validn=%b, expected 0 within 40 cycles", kif.key_validn);
        end
        checks++;
        if (kif.col_n !== 4'b1101) begin
            errors++;
            $display("FAIL press5_col_frozen: col_n=%b expected 1101", kif.col_n);
        end
        press = 16'h0000;
        wait_validn(1'b1, 30, n);
        checks++;
        if (n != 11) begin
            errors++;
            $display("FAIL press5_release_latency: %0d cycles, expected 11", n);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_bounce();
        int start_pulses;
        int n;
        start_pulses = pulse_count;
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (kif.col_n === 4'b1011) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n < 0) begin
            errors++;
            $display("FAIL bounce_col_wait: col_n=%b, expected 1011 within 20 cycles", kif.col_n);
        end
        press = 16'h4000; @(negedge clk);   // "#": row 3, col 2
        press = 16'h0000; @(negedge clk);
        press = 16'h4000; @(negedge clk);
        press = 16'h0000; repeat (2) @(negedge clk);
        press = 16'h4000;
        exp_q.push_back(4'hF);
        wait_validn(1'b0, 60, n);
        checks++;
        if (n < 0) begin
            errors++;
            $display("FAIL bounce_timeout: key_validn=%b, expected 0 within 60 cycles", kif.key_validn);
        end
        repeat (20) @(negedge clk);
        press = 16'h0000;
        wait_validn(1'b1, 30, n);
        checks++;
        if (n != 11) begin
            errors++;
            $display("FAIL bounce_release_latency: %0d cycles, expected 11", n);
        end
        checks++;
        if (pulse_count - start_pulses != 1) begin
            errors++;
            $display("FAIL bounce_pulse_count: %0d pulses, expected 1", pulse_count - start_pulses);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_open_glitch();
        int   start_pulses;
        int   n;
        logic stayed_low;
        start_pulses = pulse_count;
        press = 16'h0100;          // "7": row 2, col 0
        exp_q.push_back(4'h7);
        wait_validn(1'b0, 60, n);
        checks++;
        if (n < 0) begin
            errors++;
            $display("FAIL glitch7_timeout: key_validn=%b, expected 0 within 60 cycles", kif.key_validn);
        end
        stayed_low = 1'b1;
        for (int i = 0; i < 34; i++) begin
            if (i == 10) press = 16'h0000;
            if (i == 14) press = 16'h0100;
            @(negedge clk);
            if (kif.key_validn !== 1'b0 || kif.key_code !== 4'h7) stayed_low = 1'b0;
        end
        checks++;
        if (!stayed_low) begin
            errors++;
            $display("FAIL glitch7_held: strobe or code disturbed, now validn=%b code=%h expected 0/7",
                     kif.key_validn, kif.key_code);
        end
        press = 16'h0000;
        wait_validn(1'b1, 30, n);
        checks++;
        if (n != 11) begin
            errors++;
            $display("FAIL glitch7_release_latency: %0d cycles, expected 11", n);
        end
        checks++;
        if (pulse_count - start_pulses != 1) begin
            errors++;
            $display("FAIL glitch7_pulse_count: %0d pulses, expected 1", pulse_count - start_pulses);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_ghost();
        int         start_pulses;
        logic [3:0] seen;
        logic       stayed_high;
        start_pulses = pulse_count;
        seen         = 4'h0;
        stayed_high  = 1'b1;
        press = 16'h0202;          // "2" and "8": rows 0 and 2, col 1
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            seen = seen | ~kif.col_n;
            if (kif.key_validn !== 1'b1) stayed_high = 1'b0;
        end
        checks++;
        if (seen !== 4'hF) begin
            errors++;
            $display("FAIL ghost_scan: columns driven mask=%b expected 1111", seen);
        end
        checks++;
        if (!stayed_high || pulse_count != start_pulses) begin
            errors++;
            $display("FAIL ghost_no_press: %0d pulses, expected 0", pulse_count - start_pulses);
        end
        press = 16'h0000;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid_held();
        int start_pulses;
        int n;
        start_pulses = pulse_count;
        press = 16'h1000;          // "E": row 3, col 0
        exp_q.push_back(4'hE);
        wait_validn(1'b0, 60, n);
        checks++;
        if (n < 0) begin
            errors++;
            $display("FAIL rstE_first_timeout: key_validn=%b, expected 0 within 60 cycles", kif.key_validn);
        end
        repeat (5) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (kif.col_n !== 4'b1110 || kif.key_validn !== 1'b1 || kif.key_code !== 4'h0) begin
            errors++;
            $display("FAIL rstE_async: col_n=%b validn=%b code=%h, expected 1110/1/0",
                     kif.col_n, kif.key_validn, kif.key_code);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        exp_q.push_back(4'hE);
        wait_validn(1'b0, 60, n);
        checks++;
        if (n < 0) begin
            errors++;
            $display("FAIL rstE_redetect_timeout: key_validn=%b, expected 0 within 60 cycles", kif.key_validn);
        end
        checks++;
        if (kif.key_code !== 4'hE) begin
            errors++;
            $display("FAIL rstE_code: got %h expected e", kif.key_code);
        end
        repeat (5) @(negedge clk);
        press = 16'h0000;
        wait_validn(1'b1, 30, n);
        checks++;
        if (n != 11) begin
            errors++;
            $display("FAIL rstE_release_latency: %0d cycles, expected 11", n);
        end
        checks++;
        if (pulse_count - start_pulses != 2) begin
            errors++;
            $display("FAIL rstE_pulse_count: %0d pulses, expected 2", pulse_count - start_pulses);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_open_glitch();
        test_ghost();
        test_reset_mid_held();
        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d expected codes never strobed, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
